// File: rtl/part_buf_sequencer_if.sv
// Handshake bundle between a wide producer, the part buffer sequencer and a narrow consumer.
// slave is the sequencer side; master is the producer/consumer side.
interface part_buf_sequencer_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_PARTS = 4
);
    localparam int PART_W = DATA_W / NUM_PARTS;
    localparam int CNT_W  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PART_W-1:0] out_data;
    logic [CNT_W-1:0]  out_idx;
    logic              out_last;
    logic              abort;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready, abort,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, abort,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/part_buf_sequencer.sv
// Latches one DATA_W word and streams it out as NUM_PARTS slices of DATA_W/NUM_PARTS bits.
// Define PART_BUF_MSB_FIRST_EN to emit the most significant slice first.
module part_buf_sequencer #(
    parameter int DATA_W    = 32,
    parameter int NUM_PARTS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    part_buf_sequencer_if.slave   bus
);
    localparam int PART_W = DATA_W / NUM_PARTS;
    localparam int CNT_W  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PARTS - 1);

    if (NUM_PARTS < 1) begin : g_bad_num_parts
        $error("part_buf_sequencer: NUM_PARTS must be at least 1");
    end else if ((DATA_W % NUM_PARTS) != 0) begin : g_bad_data_w
        $error("part_buf_sequencer: DATA_W must be a multiple of NUM_PARTS");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    logic sending;
    logic last_part;
    logic in_ready_c;
    logic in_fire;
    logic out_fire;
    int   shamt;

    always_comb begin
        sending    = (state_q == SEND);
        last_part  = sending && (idx_q == LAST_IDX);
        in_ready_c = !rst && !bus.abort && (!sending || (last_part && bus.out_ready));
        in_fire    = bus.in_valid && in_ready_c;
        out_fire   = sending && bus.out_ready;
`ifdef PART_BUF_MSB_FIRST_EN
        shamt = (DATA_W - PART_W) - int'(idx_q) * PART_W;
`else
        shamt = int'(idx_q) * PART_W;
`endif
        bus.in_ready  = in_ready_c;
        bus.out_valid = sending;
        bus.busy      = sending;
        bus.out_last  = last_part;
        bus.out_idx   = idx_q;
        bus.out_data  = PART_W'(data_buf_q >> shamt);
    end

    // Abort overrides any handshake; a part delivered in the abort cycle is simply not followed by more.
    always_comb begin
        state_d    = state_q;
        data_buf_d = data_buf_q;
        idx_d      = idx_q;
        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (!sending) begin
            if (in_fire) begin
                data_buf_d = bus.in_data;
                idx_d      = '0;
                state_d    = SEND;
            end
        end else if (out_fire) begin
            if (!last_part) begin
                idx_d = idx_q + CNT_W'(1);
            end else if (in_fire) begin
                data_buf_d = bus.in_data;
                idx_d      = '0;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_buf_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_buf_q <= data_buf_d;
            idx_q      <= idx_d;
        end
    end
endmodule

// File: tb/tb_part_buf_sequencer.sv
// Self-checking bench: directed test-plan sequences plus random traffic against a queue-of-parts model,
// and a short directed check of a NUM_PARTS=1 instance.
module tb_part_buf_sequencer;
    localparam int DW = 32;
    localparam int NP = 4;
    localparam int PW = DW / NP;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] exp_q[$];
    bit            fresh;

    part_buf_sequencer_if #(.DATA_W(DW), .NUM_PARTS(NP)) bus ();
    part_buf_sequencer_if #(.DATA_W(DW), .NUM_PARTS(1))  bus1 ();

    part_buf_sequencer #(.DATA_W(DW), .NUM_PARTS(NP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    part_buf_sequencer #(.DATA_W(DW), .NUM_PARTS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] part_of(logic [DW-1:0] w, int p);
        int sh;
`ifdef PART_BUF_MSB_FIRST_EN
        sh = (NP - 1 - p) * PW;
`else
        sh = p * PW;
`endif
        return PW'(w >> sh);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the queue of parts still owed to the consumer.
    task automatic checkOutput(input bit r_rst, input bit a, input bit r, output bit exp_rdy);
        int n;
        n = exp_q.size();
        exp_rdy = !r_rst && !a && (n == 0 || (n == 1 && r));
        check("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(n != 0));
        check("busy",      32'(bus.busy),      32'(n != 0));
        check("out_last",  32'(bus.out_last),  32'(n == 1));
        check("out_idx",   32'(bus.out_idx),   (n != 0) ? 32'(NP - n) : 32'd0);
        if (n != 0)
            check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        else if (fresh)
            check("out_data_rst", 32'(bus.out_data), 32'd0);
    endtask

    task automatic applyStimulus(input bit r_rst, input bit v, input logic [DW-1:0] d,
                                 input bit r, input bit a);
        bit exp_rdy;
        @(negedge clk);
        rst           = r_rst;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.abort     = a;
        #1;
        checkOutput(r_rst, a, r, exp_rdy);
        if (r_rst) begin
            exp_q.delete();
            fresh = 1'b1;
        end else begin
            if (exp_q.size() != 0 && r)
                void'(exp_q.pop_front());
            if (a)
                exp_q.delete();
            else if (v && exp_rdy) begin
                for (int p = 0; p < NP; p++)
                    exp_q.push_back(part_of(d, p));
                fresh = 1'b0;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.abort      = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        bus1.abort     = 1'b0;
        fresh          = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] reset hold and release");
        applyStimulus(1, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] single word");
        applyStimulus(0, 1, 32'hDDCCBBAA, 1, 0);
        repeat (5) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] backpressure on part 1");
        applyStimulus(0, 1, 32'hDDCCBBAA, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        repeat (3) applyStimulus(0, 0, '0, 0, 0);
        repeat (5) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] back-to-back words");
        applyStimulus(0, 1, 32'h33221100, 1, 0);
        repeat (4) applyStimulus(0, 1, 32'h77665544, 1, 0);
        repeat (5) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] abort after part 1");
        applyStimulus(0, 1, 32'hDDCCBBAA, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h44332211, 1, 1);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h44332211, 1, 0);
        repeat (5) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] reset mid-word");
        applyStimulus(0, 1, 32'hDDCCBBAA, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(1, 1, 32'h12345678, 1, 0);
        applyStimulus(1, 1, 32'h12345678, 1, 0);
        repeat (3) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 100) == 0, ($urandom % 4) != 0, $urandom,
                          ($urandom % 3) != 0, ($urandom % 25) == 0);
        repeat (6) applyStimulus(0, 0, '0, 1, 0);

        $display("[TB] single-part instance");
        @(negedge clk);
        rst            = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 32'hDDCCBBAA;
        bus1.out_ready = 1'b1;
        #1;
        check("np1_in_ready_idle", 32'(bus1.in_ready), 32'd1);
        check("np1_valid_idle",    32'(bus1.out_valid), 32'd0);
        @(negedge clk);
        bus1.in_data = 32'h01234567;
        #1;
        check("np1_valid",    32'(bus1.out_valid), 32'd1);
        check("np1_data0",    32'(bus1.out_data),  32'hDDCCBBAA);
        check("np1_last",     32'(bus1.out_last),  32'd1);
        check("np1_idx",      32'(bus1.out_idx),   32'd0);
        check("np1_in_ready", 32'(bus1.in_ready),  32'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        check("np1_data1",    32'(bus1.out_data),  32'h01234567);
        check("np1_last1",    32'(bus1.out_last),  32'd1);
        @(negedge clk);
        #1;
        check("np1_busy_end", 32'(bus1.busy),      32'd0);
        check("np1_valid_end", 32'(bus1.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
